// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes,
// ALU operations and PC source selects.
package mc_ctrl_pkg;

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // R-type only defines the four lowest funct codes.
    function automatic logic is_legal(input logic [3:0] op, input logic [3:0] funct);
        case (op)
            OP_RTYPE:                                       return (funct[3:2] == 2'b00);
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_JMP:  return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory-ready wait cycles; expired flags the last tolerated cycle.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int          WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [WAIT_W-1:0] count;

    assign expired = (count == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (count_en && !expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle 16-bit CPU.
// Define MC_PERF_CNT_EN to build the retire/stall performance counters.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int          WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [3:0]  Funct_field,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  ALU_op,
    output logic        ALU_Src,
    output logic        IorD,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic        Reg_Write,
    output logic        Mem_to_Reg,
    output logic        retire,
    output logic        fault,
    output logic [15:0] instr_count,
    output logic [15:0] stall_count
);

    logic [2:0] state, state_d;
    logic       waiting, expired;

    assign waiting = (state == FETCH || state == MEM) && !mem_ready;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_d != state),
        .count_en (waiting),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_d;
    end

    // Reset forces every strobe low in the cycle it is asserted.
    always_comb begin
        state_d    = state;
        ALU_op     = ALU_ADD;
        ALU_Src    = 1'b0;
        IorD       = 1'b0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        PC_Src     = PC_SEQ;
        Reg_Write  = 1'b0;
        Mem_to_Reg = 1'b0;
        retire     = 1'b0;
        fault      = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    Mem_Read = 1'b1;
                    if (mem_ready) begin
                        IR_Write = 1'b1;
                        PC_Write = 1'b1;
                        state_d  = DECODE;
                    end else if (expired) begin
                        state_d = FAULT;
                    end
                end
                DECODE: state_d = is_legal(opcode, Funct_field) ? EXEC : FAULT;
                EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            ALU_op  = Funct_field;
                            state_d = WB;
                        end
                        OP_LW, OP_SW: begin
                            ALU_Src = 1'b1;
                            state_d = MEM;
                        end
                        OP_ADDI: begin
                            ALU_Src = 1'b1;
                            state_d = WB;
                        end
                        OP_BEQ, OP_BNE: begin
                            ALU_op = ALU_SUB;
                            if ((opcode == OP_BEQ) == Zero) begin
                                PC_Write = 1'b1;
                                PC_Src   = PC_BRANCH;
                            end
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                        OP_JMP: begin
                            PC_Write = 1'b1;
                            PC_Src   = PC_JUMP;
                            retire   = 1'b1;
                            state_d  = FETCH;
                        end
                        default: state_d = FAULT;
                    endcase
                end
                MEM: begin
                    IorD      = 1'b1;
                    ALU_Src   = 1'b1;
                    Mem_Read  = (opcode == OP_LW);
                    Mem_Write = (opcode == OP_SW);
                    if (mem_ready) begin
                        if (opcode == OP_LW) begin
                            state_d = WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    end else if (expired) begin
                        state_d = FAULT;
                    end
                end
                WB: begin
                    Reg_Write  = 1'b1;
                    Mem_to_Reg = (opcode == OP_LW);
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                FAULT:   fault   = 1'b1;
                default: state_d = FAULT;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (retire && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
            if (waiting && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (built with MAX_WAIT=4).
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode, Funct_field;
    logic        Zero, mem_ready;
    logic [3:0]  ALU_op;
    logic        ALU_Src, IorD, Mem_Read, Mem_Write, IR_Write, PC_Write;
    logic [1:0]  PC_Src;
    logic        Reg_Write, Mem_to_Reg, retire, fault;
    logic [15:0] instr_count, stall_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        r;
        logic [3:0]  op;
        logic [3:0]  fn;
        logic        z;
        logic        mr;
        logic [15:0] exp;
    } vec_t;

    logic [15:0] sb[$];
    logic [15:0] obs, want;

    assign obs = {ALU_op, ALU_Src, IorD, Mem_Read, Mem_Write, IR_Write, PC_Write,
                  PC_Src, Reg_Write, Mem_to_Reg, retire, fault};

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .Funct_field(Funct_field),
        .Zero(Zero), .mem_ready(mem_ready), .ALU_op(ALU_op), .ALU_Src(ALU_Src),
        .IorD(IorD), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .PC_Write(PC_Write), .PC_Src(PC_Src), .Reg_Write(Reg_Write),
        .Mem_to_Reg(Mem_to_Reg), .retire(retire), .fault(fault),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    function automatic logic [15:0] ov(input logic [3:0] alu, input logic src, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic pcw, input logic [1:0] pcs, input logic rw,
                                       input logic m2r, input logic ret, input logic flt);
        return {alu, src, iord, mrd, mwr, irw, pcw, pcs, rw, m2r, ret, flt};
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] op, input logic [3:0] fn,
                                input logic z, input logic mr, input logic [15:0] e);
        return '{r: r, op: op, fn: fn, z: z, mr: mr, exp: e};
    endfunction

    localparam logic [15:0] NONE = 16'h0000;
    localparam logic [15:0] FW   = 16'h0200;  // fetch waiting: Mem_Read only
    localparam logic [15:0] FR   = 16'h02C0;  // fetch ready: Mem_Read, IR_Write, PC_Write
    localparam logic [15:0] FLT  = 16'h0001;

    logic [15:0] exp_ic, exp_sc;

    task automatic drive(input vec_t v);
        rst = v.r; opcode = v.op; Funct_field = v.fn; Zero = v.z; mem_ready = v.mr;
        sb.push_back(v.exp);
    endtask

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk(1, 4'h0, 4'h2, 1'b0, 1'b1, NONE));
        v.push_back(mk(1, 4'h6, 4'h0, 1'b1, 1'b1, NONE));
        v.push_back(mk(0, 4'h0, 4'h0, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL reset[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
        vectors++;
        if (instr_count !== 16'd0 || stall_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got ic=%0d sc=%0d want 0/0", instr_count, stall_count);
        end
    endtask

    task automatic test_rtype();
        vec_t v[$];
        v.push_back(mk(1, 4'h0, 4'h2, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h0, 4'h2, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h0, 4'h2, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h0, 4'h2, 1'b0, 1'b0, ov(4'h2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(0, 4'h0, 4'h2, 1'b0, 1'b0, ov(4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0)));
        v.push_back(mk(0, 4'h0, 4'h2, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL rtype[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        vec_t v[$];
        logic [15:0] memrd;
        memrd = ov(4'h0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        v.push_back(mk(1, 4'h1, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        for (int k = 0; k < 3; k++) v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, memrd));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b1, memrd));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, ov(4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0)));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b1, FR));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL lw_wait[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
`ifdef MC_PERF_CNT_EN
        exp_ic = 16'd1; exp_sc = 16'd3;
`else
        exp_ic = 16'd0; exp_sc = 16'd0;
`endif
        @(negedge clk);
        vectors++;
        if (instr_count !== exp_ic || stall_count !== exp_sc) begin
            miscompares++;
            $display("FAIL lw_counters: got ic=%0d sc=%0d want %0d/%0d", instr_count, stall_count, exp_ic, exp_sc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        vec_t v[$];
        v.push_back(mk(1, 4'h4, 4'h0, 1'b1, 1'b1, NONE));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b1, 1'b1, FR));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b1, 1'b0, NONE));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b1, 1'b0, ov(4'h1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b1, 1'b1, FR));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b1, 1'b0, NONE));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b1, 1'b0, ov(4'h1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h5, 4'h0, 1'b0, 1'b0, ov(4'h1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h4, 4'h0, 1'b0, 1'b0, ov(4'h1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h6, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h6, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h6, 4'h0, 1'b0, 1'b0, ov(4'h0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h6, 4'h0, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL branch[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back(mk(1, 4'h2, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b1, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b1, ov(4'h0, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0)));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, ov(4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0)));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
`ifdef MC_PERF_CNT_EN
        exp_ic = 16'd2;
`else
        exp_ic = 16'd0;
`endif
        @(negedge clk);
        vectors++;
        if (instr_count !== exp_ic) begin
            miscompares++;
            $display("FAIL b2b_instr_count: got %0d want %0d", instr_count, exp_ic);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(mk(1, 4'h9, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h9, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h9, 4'h0, 1'b0, 1'b1, NONE));
        for (int k = 0; k < 20; k++)
            v.push_back(mk(0, 4'($urandom_range(0, 15)), 4'h0, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), FLT));
        v.push_back(mk(1, 4'h0, 4'h7, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h0, 4'h7, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h0, 4'h7, 1'b0, 1'b1, NONE));
        for (int k = 0; k < 3; k++) v.push_back(mk(0, 4'h0, 4'h7, 1'b0, 1'b1, FLT));
        v.push_back(mk(1, 4'h0, 4'h7, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h0, 4'h7, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL illegal[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        vec_t v[$];
        logic [15:0] memrd;
        memrd = ov(4'h0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        v.push_back(mk(1, 4'h3, 4'h0, 1'b0, 1'b0, NONE));
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, FW));
        for (int k = 0; k < 4; k++) v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, FLT));
        v.push_back(mk(1, 4'h3, 4'h0, 1'b0, 1'b0, NONE));
        for (int k = 0; k < 4; k++) v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, FW));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(0, 4'h3, 4'h0, 1'b0, 1'b0, ov(4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0)));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b0, memrd));
        for (int k = 0; k < 2; k++) v.push_back(mk(0, 4'h1, 4'h0, 1'b0, 1'b1, FLT));
        v.push_back(mk(1, 4'h1, 4'h0, 1'b0, 1'b1, NONE));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL timeout[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_mid_mem();
        vec_t v[$];
        v.push_back(mk(1, 4'h2, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b1, FR));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b0, NONE));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b0, ov(4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b0, ov(4'h0, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0)));
        v.push_back(mk(1, 4'h2, 4'h0, 1'b0, 1'b1, NONE));
        v.push_back(mk(0, 4'h2, 4'h0, 1'b0, 1'b0, FW));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            want = sb.pop_front(); vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL rst_mid_mem[%0d]: got %h want %h", i, obs, want); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if (instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid_instr_count: got %0d want 0", instr_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; Funct_field = 4'h0; Zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_rst_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
